imem_sync: RTL and testbench

Parametrised, synchronous-read instruction memory for the single-cycle/multi-cycle CPU labs, replacing the fixed 32×32 combinational ROM. It self-clears to NOP after reset and accepts program loads through a write port, so test programs are loaded from the bench instead of being hard-coded. It also serves fetches from the PC with one-cycle latency, a stall/hold input and out-of-range detection. It sits between the PC register and the decode stage.

---
 rtl/imem_sync.sv | 133 +++++++++++++
 tb/tb_imem_sync.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_sync                                                     |
// | Purpose  : Synchronous-read instruction memory. After reset it sweeps    |
// |            every word to NOP_WORD, then it accepts program loads and     |
// |            serves PC fetches with one cycle of latency. It supports a    |
// |            stall/hold input and reports out-of-range accesses.           |
// | Ports    : clk_i, reset_i (async, active-high)                           |
// |            ready_o                       - clear sweep finished          |
// |            prog_we_i/prog_addr_i/        - program-load write port       |
// |            prog_data_i                                                   |
// |            prog_err_o                    - one-cycle rejected-write pulse|
// |            fetch_en_i/stall_i/pc_i       - fetch request                 |
// |            instr_o/instr_valid_o/        - registered fetch result       |
// |            addr_err_o                                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module imem_sync #(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 32,
  parameter int          PC_W     = 5,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              ready_o,
  input  logic              prog_we_i,
  input  logic [PC_W-1:0]   prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic              prog_err_o,
  input  logic              fetch_en_i,
  input  logic              stall_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid_o,
  output logic              addr_err_o
);

  // Index width of the storage array; never wider than PC_W because
  // 2^PC_W >= DEPTH.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              state_q;
  logic [AW-1:0]       clr_cnt_q;
  logic [AW-1:0]       clr_cnt_d;
  logic                ready_q;
  logic [DATA_W-1:0]   instr_q;
  logic [DATA_W-1:0]   instr_d;
  logic                instr_valid_q;
  logic                addr_err_q;
  logic                prog_err_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                pc_in_range;
  logic                prog_in_range;
  logic                wr_ok;
  logic                fetch_go;

  // Range checks use the full address width, so there is no aliasing onto
  // the array when DEPTH is not a power of two.
  assign pc_in_range   = (32'(pc_i) < 32'(DEPTH));
  assign prog_in_range = (32'(prog_addr_i) < 32'(DEPTH));

  assign wr_ok     = (state_q == S_READY) && prog_we_i && prog_in_range;
  assign fetch_go  = (state_q == S_READY) && fetch_en_i && !stall_i;
  assign clr_cnt_d = clr_cnt_q + 1'b1;
  assign instr_d   = pc_in_range ? mem_q[pc_i[AW-1:0]] : NOP_WORD;

  // Storage has no reset; it is initialised by the clear sweep instead.
  // Reads in the control block see the pre-edge contents, so a same-cycle
  // write/fetch to one address returns the old word (read-first).
  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_cnt_q] <= NOP_WORD;
    end else if (wr_ok) begin
      mem_q[prog_addr_i[AW-1:0]] <= prog_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= '0;
      ready_q       <= 1'b0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      prog_err_q    <= 1'b0;
    end else begin
      // Any write attempt outside READY, or past the array, is rejected.
      prog_err_q <= prog_we_i && ((state_q != S_READY) || !prog_in_range);

      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_d;
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end
        end
        S_READY: begin
          ready_q <= 1'b1;
          if (fetch_go) begin
            instr_q       <= instr_d;
            instr_valid_q <= 1'b1;
            addr_err_q    <= !pc_in_range;
          end else if (!stall_i) begin
            // Idle cycle: drop valid but keep the last word and its flag.
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_CLEAR;
        end
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign prog_err_o    = prog_err_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign addr_err_o    = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_imem_sync                                                  |
// | Purpose  : Directed self-checking bench for imem_sync. Two instances     |
// |            share every input: u32 (DEPTH=32) and u20 (DEPTH=20), both    |
// |            with PC_W=5.                                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_imem_sync;

  localparam int DATA_W = 32;
  localparam int PC_W   = 5;

  logic              clk;
  logic              r_reset;
  logic              r_prog_we;
  logic [PC_W-1:0]   r_prog_addr;
  logic [DATA_W-1:0] r_prog_data;
  logic              r_fetch_en;
  logic              r_stall;
  logic [PC_W-1:0]   r_pc;

  logic              w_ready_a, w_prog_err_a, w_valid_a, w_aerr_a;
  logic [DATA_W-1:0] w_instr_a;
  logic              w_ready_b, w_prog_err_b, w_valid_b, w_aerr_b;
  logic [DATA_W-1:0] w_instr_b;

  int n_total = 0;
  int n_bad   = 0;

  imem_sync #(.DATA_W(DATA_W), .DEPTH(32), .PC_W(PC_W), .NOP_WORD('0)) u32 (
    .clk_i        (clk),
    .reset_i      (r_reset),
    .ready_o      (w_ready_a),
    .prog_we_i    (r_prog_we),
    .prog_addr_i  (r_prog_addr),
    .prog_data_i  (r_prog_data),
    .prog_err_o   (w_prog_err_a),
    .fetch_en_i   (r_fetch_en),
    .stall_i      (r_stall),
    .pc_i         (r_pc),
    .instr_o      (w_instr_a),
    .instr_valid_o(w_valid_a),
    .addr_err_o   (w_aerr_a)
  );

  imem_sync #(.DATA_W(DATA_W), .DEPTH(20), .PC_W(PC_W), .NOP_WORD('0)) u20 (
    .clk_i        (clk),
    .reset_i      (r_reset),
    .ready_o      (w_ready_b),
    .prog_we_i    (r_prog_we),
    .prog_addr_i  (r_prog_addr),
    .prog_data_i  (r_prog_data),
    .prog_err_o   (w_prog_err_b),
    .fetch_en_i   (r_fetch_en),
    .stall_i      (r_stall),
    .pc_i         (r_pc),
    .instr_o      (w_instr_b),
    .instr_valid_o(w_valid_b),
    .addr_err_o   (w_aerr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, " a.ready"}, 32'(w_ready_a), 32'd0);
    chk({tag, " a.valid"}, 32'(w_valid_a), 32'd0);
    chk({tag, " a.instr"}, w_instr_a, 32'd0);
    chk({tag, " a.aerr"},  32'(w_aerr_a),  32'd0);
    chk({tag, " a.perr"},  32'(w_prog_err_a), 32'd0);
    chk({tag, " b.ready"}, 32'(w_ready_b), 32'd0);
    chk({tag, " b.valid"}, 32'(w_valid_b), 32'd0);
    chk({tag, " b.instr"}, w_instr_b, 32'd0);
  endtask

  task automatic write_word(input logic [PC_W-1:0] a, input logic [31:0] d);
    r_prog_we   = 1'b1;
    r_prog_addr = a;
    r_prog_data = d;
    step();
    r_prog_we   = 1'b0;
  endtask

  initial begin
    r_reset     = 1'b1;
    r_prog_we   = 1'b0;
    r_prog_addr = '0;
    r_prog_data = '0;
    r_fetch_en  = 1'b1;
    r_stall     = 1'b0;
    r_pc        = 5'd7;
    #1;
    chk_rst_vals("por");
    step();
    step();
    #2;
    r_reset = 1'b0;

    // Clear sweep with fetch_en held high on pc=7.
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("sweep a.ready", 32'(w_ready_a), 32'(k >= 32));
      chk("sweep a.valid", 32'(w_valid_a), 32'd0);
      chk("sweep b.ready", 32'(w_ready_b), 32'(k >= 20));
      chk("sweep b.valid", 32'(w_valid_b), 32'(k >= 21));
    end
    step();
    chk("first fetch a.instr", w_instr_a, 32'h0000_0000);
    chk("first fetch a.valid", 32'(w_valid_a), 32'd1);
    chk("first fetch a.aerr",  32'(w_aerr_a), 32'd0);

    // Program load and back-to-back fetch.
    r_fetch_en = 1'b0;
    write_word(5'd0, 32'hC000_500A);
    chk("load0 perr", 32'(w_prog_err_a), 32'd0);
    chk("idle a.valid", 32'(w_valid_a), 32'd0);
    chk("idle a.instr hold", w_instr_a, 32'h0000_0000);
    write_word(5'd1, 32'hC000_780F);
    r_fetch_en = 1'b1;
    r_pc = 5'd0;
    step();
    chk("fetch0 a.instr", w_instr_a, 32'hC000_500A);
    chk("fetch0 a.valid", 32'(w_valid_a), 32'd1);
    chk("fetch0 b.instr", w_instr_b, 32'hC000_500A);
    r_pc = 5'd1;
    step();
    chk("fetch1 a.instr", w_instr_a, 32'hC000_780F);
    chk("fetch1 a.valid", 32'(w_valid_a), 32'd1);

    // Stall: hold mem[3] while pc moves; a write during the stall lands.
    r_fetch_en = 1'b0;
    write_word(5'd3, 32'h3333_3333);
    write_word(5'd4, 32'h4444_4444);
    write_word(5'd5, 32'h5555_5555);
    write_word(5'd6, 32'h6666_6666);
    r_fetch_en = 1'b1;
    r_pc = 5'd3;
    step();
    chk("stall pre a.instr", w_instr_a, 32'h3333_3333);
    r_stall = 1'b1;
    for (int i = 4; i <= 6; i++) begin
      r_pc = 5'(i);
      if (i == 5) begin
        r_prog_we = 1'b1; r_prog_addr = 5'd8; r_prog_data = 32'h8888_8888;
      end else begin
        r_prog_we = 1'b0;
      end
      step();
      chk("stall hold a.instr", w_instr_a, 32'h3333_3333);
      chk("stall hold a.valid", 32'(w_valid_a), 32'd1);
    end
    r_prog_we = 1'b0;
    r_stall = 1'b0;
    step();
    chk("stall release a.instr", w_instr_a, 32'h6666_6666);
    r_pc = 5'd8;
    step();
    chk("write in stall a.instr", w_instr_a, 32'h8888_8888);

    // Out-of-range fetch and write on the DEPTH=20 instance.
    r_pc = 5'd25;
    step();
    chk("oor b.instr", w_instr_b, 32'h0000_0000);
    chk("oor b.valid", 32'(w_valid_b), 32'd1);
    chk("oor b.aerr",  32'(w_aerr_b), 32'd1);
    chk("inr a.aerr",  32'(w_aerr_a), 32'd0);
    r_fetch_en = 1'b0;
    write_word(5'd25, 32'hBAD0_BAD0);
    chk("oor write b.perr", 32'(w_prog_err_b), 32'd1);
    chk("inr write a.perr", 32'(w_prog_err_a), 32'd0);
    chk("idle b.aerr hold", 32'(w_aerr_b), 32'd1);
    write_word(5'd19, 32'h1919_1919);
    chk("pulse end b.perr", 32'(w_prog_err_b), 32'd0);
    r_fetch_en = 1'b1;
    r_pc = 5'd25;
    step();
    chk("fetch25 a.instr", w_instr_a, 32'hBAD0_BAD0);
    chk("fetch25 b.instr", w_instr_b, 32'h0000_0000);
    r_pc = 5'd19;
    step();
    chk("edge19 b.instr", w_instr_b, 32'h1919_1919);
    chk("edge19 b.aerr",  32'(w_aerr_b), 32'd0);
    r_pc = 5'd20;
    step();
    chk("edge20 b.aerr",  32'(w_aerr_b), 32'd1);
    chk("edge20 b.instr", w_instr_b, 32'h0000_0000);

    // Same-cycle write/fetch collision is read-first.
    r_fetch_en = 1'b0;
    write_word(5'd12, 32'h1111_1111);
    r_fetch_en  = 1'b1;
    r_pc        = 5'd12;
    r_prog_we   = 1'b1;
    r_prog_addr = 5'd12;
    r_prog_data = 32'hDEAD_BEEF;
    step();
    r_prog_we = 1'b0;
    chk("collide old a.instr", w_instr_a, 32'h1111_1111);
    step();
    chk("collide new a.instr", w_instr_a, 32'hDEAD_BEEF);

    // Asynchronous reset mid-operation, then again mid-sweep.
    #2;
    r_reset = 1'b1;
    #1;
    chk_rst_vals("async rst");
    step();
    #2;
    r_reset = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    #2;
    r_reset = 1'b1;
    #1;
    chk_rst_vals("sweep rst");
    step();
    #2;
    r_reset = 1'b0;
    r_pc = 5'd0;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("resweep a.ready", 32'(w_ready_a), 32'(k >= 32));
      chk("resweep b.ready", 32'(w_ready_b), 32'(k >= 20));
      chk("resweep a.valid", 32'(w_valid_a), 32'd0);
      chk("resweep a.perr",  32'(w_prog_err_a), 32'(k == 4));
      r_prog_we = (k == 3);
    end
    r_prog_we = 1'b0;
    step();
    chk("recleared a.instr", w_instr_a, 32'h0000_0000);
    chk("recleared a.valid", 32'(w_valid_a), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
